// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the packet-RAM slot scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pkt_sched_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_AW   = 7;
  localparam int SLOT_IW   = 2;
  localparam int ADDR_W    = SLOT_IW + SLOT_AW;

  // Ownership stage of one RAM slot
  typedef enum logic [2:0] {
    ST_FREE = 3'd0,
    ST_FILL = 3'd1,
    ST_CPU  = 3'd2,
    ST_OUT  = 3'd3,
    ST_SEND = 3'd4
  } slot_st_e;

  // First RAM entry of a slot
  function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_IW-1:0] slot);
    return {slot, {SLOT_AW{1'b0}}};
  endfunction

endpackage

// File: rtl/pkt_slot_sched_rr_arbiter.sv
// 4-way round-robin pick: first requester strictly after i_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_arbiter
  import pkt_sched_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] i_req,
  input  logic [SLOT_IW-1:0]   i_ptr,
  output logic                 o_vld,
  output logic [SLOT_IW-1:0]   o_idx
);

  logic [SLOT_IW-1:0] w_cand;

  // Walk from farthest to nearest so the slot just after i_ptr wins
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      w_cand = i_ptr + SLOT_IW'(k);
      if (i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/pkt_slot_sched.sv
// Slot ownership scheduler for the 4x128-entry packet RAM (alloc, CPU queue, RR egress).
// Latency: every output registered; grants, CPU head and egress offers appear 1 cycle after their cause.
// Backpressure: alloc waits for a FREE slot; egress offer holds until i_out_ready; one slot in SEND at a time.
// Optional: PKT_SCHED_WDT_EN adds a per-slot CPU-stage watchdog that force-drops stale slots.
module pkt_slot_sched
  import pkt_sched_pkg::*;
#(
  parameter logic [15:0] WDT_CYCLES = 16'hFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_alloc_req,
  output logic               o_alloc_gnt,
  output logic [SLOT_IW-1:0] o_alloc_slot,
  output logic [ADDR_W-1:0]  o_alloc_base,
  input  logic               i_fill_done,
  input  logic [SLOT_IW-1:0] i_fill_slot,
  output logic               o_cpu_pkt_valid,
  output logic [SLOT_IW-1:0] o_cpu_pkt_slot,
  input  logic               i_cpu_done,
  input  logic               i_cpu_drop,
  output logic               o_out_valid,
  output logic [SLOT_IW-1:0] o_out_slot,
  output logic [ADDR_W-1:0]  o_out_base,
  input  logic               i_out_ready,
  input  logic               i_release,
  input  logic [SLOT_IW-1:0] i_release_slot,
  output logic [31:0]        o_cnt_in,
  output logic [31:0]        o_cnt_out,
  output logic [31:0]        o_cnt_drop,
  output logic               o_err_sticky
);

  slot_st_e           r_st [NUM_SLOTS];
  logic [SLOT_IW-1:0] r_q  [NUM_SLOTS];
  logic [SLOT_IW:0]   r_qcnt;
  logic               r_cpu_valid;
  logic [SLOT_IW-1:0] r_rr_ptr;
  logic               r_alloc_gnt;
  logic [SLOT_IW-1:0] r_alloc_slot;
  logic [ADDR_W-1:0]  r_alloc_base;
  logic               r_out_valid;
  logic [SLOT_IW-1:0] r_out_slot;
  logic [ADDR_W-1:0]  r_out_base;
  logic [31:0]        r_cnt_in;
  logic [31:0]        r_cnt_out;
  logic [31:0]        r_cnt_drop;
  logic               r_err;

  logic               w_free_any;
  logic [SLOT_IW-1:0] w_free_idx;
  logic               w_alloc_fire;
  logic               w_fill_ok;
  logic               w_fill_err;
  logic [SLOT_IW-1:0] w_q_head;
  logic               w_pop;
  logic               w_pop_err;
  logic               w_accept;
  logic               w_rel_ok;
  logic               w_rel_err;
  logic               w_send_busy;
  logic [NUM_SLOTS-1:0] w_out_req;
  logic               w_arb_vld;
  logic [SLOT_IW-1:0] w_arb_idx;
  logic               w_offer;
  logic               w_wdt_fire;
  logic [SLOT_IW-1:0] w_wdt_slot;
  logic [SLOT_IW-1:0] w_q_nxt [NUM_SLOTS];
  logic [SLOT_IW:0]   w_qcnt_nxt;

  // Lowest-index FREE slot, plus SEND/OUT occupancy for egress
  always_comb begin
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    w_send_busy = 1'b0;
    w_out_req   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (r_st[i] == ST_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = SLOT_IW'(i);
      end
      if (r_st[i] == ST_SEND) w_send_busy = 1'b1;
      w_out_req[i] = (r_st[i] == ST_OUT);
    end
  end

  assign w_alloc_fire = i_alloc_req & ~r_alloc_gnt & w_free_any;
  assign w_fill_ok    = i_fill_done & (r_st[i_fill_slot] == ST_FILL);
  assign w_fill_err   = i_fill_done & ~w_fill_ok;
  assign w_q_head     = r_q[0];
  assign w_pop        = i_cpu_done & (r_qcnt != '0);
  assign w_pop_err    = i_cpu_done & (r_qcnt == '0);
  assign w_accept     = r_out_valid & i_out_ready;
  assign w_rel_ok     = i_release & (r_st[i_release_slot] == ST_SEND);
  assign w_rel_err    = i_release & ~w_rel_ok;
  assign w_offer      = ~r_out_valid & ~w_send_busy & w_arb_vld;

  rr_arbiter u_rr_arbiter (
    .i_req (w_out_req),
    .i_ptr (r_rr_ptr),
    .o_vld (w_arb_vld),
    .o_idx (w_arb_idx)
  );

`ifdef PKT_SCHED_WDT_EN
  logic [15:0] r_age [NUM_SLOTS];
  logic        w_wdt_hit;

  // Find the slot whose CPU age hits the limit this cycle (entries arrive one per cycle, so at most one)
  always_comb begin
    w_wdt_hit  = 1'b0;
    w_wdt_slot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((r_st[i] == ST_CPU) && (r_age[i] == WDT_CYCLES - 16'd1)) begin
        w_wdt_hit  = 1'b1;
        w_wdt_slot = SLOT_IW'(i);
      end
    end
  end

  // A real cpu_done on the same slot takes precedence over the timeout
  assign w_wdt_fire = w_wdt_hit & ~(w_pop & (w_q_head == w_wdt_slot));

  // Age counts only while in CPU; held at zero elsewhere so entry starts from zero
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (i_rst || (r_st[i] != ST_CPU)) r_age[i] <= '0;
      else                              r_age[i] <= r_age[i] + 16'd1;
    end
  end
`else
  logic w_unused_wdt;
  assign w_unused_wdt = ^WDT_CYCLES;
  assign w_wdt_fire   = 1'b0;
  assign w_wdt_slot   = '0;
`endif

  // Next CPU queue: drop popped/timed-out entries, compact, then append the new fill
  always_comb begin
    w_qcnt_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) w_q_nxt[i] = r_q[i];
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((SLOT_IW'(i) < r_qcnt[SLOT_IW-1:0] || r_qcnt[SLOT_IW]) &&
          !((i == 0) && w_pop) &&
          !(w_wdt_fire && (r_q[i] == w_wdt_slot))) begin
        w_q_nxt[w_qcnt_nxt[SLOT_IW-1:0]] = r_q[i];
        w_qcnt_nxt = w_qcnt_nxt + 1'b1;
      end
    end
    if (w_fill_ok) begin
      w_q_nxt[w_qcnt_nxt[SLOT_IW-1:0]] = i_fill_slot;
      w_qcnt_nxt = w_qcnt_nxt + 1'b1;
    end
  end

  // Slot ownership, CPU queue, grant/offer registers, counters and error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_st[i] <= ST_FREE;
        r_q[i]  <= '0;
      end
      r_qcnt       <= '0;
      r_cpu_valid  <= 1'b0;
      r_rr_ptr     <= SLOT_IW'(NUM_SLOTS - 1);
      r_alloc_gnt  <= 1'b0;
      r_alloc_slot <= '0;
      r_alloc_base <= '0;
      r_out_valid  <= 1'b0;
      r_out_slot   <= '0;
      r_out_base   <= '0;
      r_cnt_in     <= '0;
      r_cnt_out    <= '0;
      r_cnt_drop   <= '0;
      r_err        <= 1'b0;
    end else begin
      // Each event qualifies on a distinct current state, so these never collide on one slot
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_alloc_fire && (w_free_idx == SLOT_IW'(i)))   r_st[i] <= ST_FILL;
        if (w_fill_ok && (i_fill_slot == SLOT_IW'(i)))     r_st[i] <= ST_CPU;
        if (w_pop && (w_q_head == SLOT_IW'(i)))            r_st[i] <= i_cpu_drop ? ST_FREE : ST_OUT;
        if (w_wdt_fire && (w_wdt_slot == SLOT_IW'(i)))     r_st[i] <= ST_FREE;
        if (w_accept && (r_out_slot == SLOT_IW'(i)))       r_st[i] <= ST_SEND;
        if (w_rel_ok && (i_release_slot == SLOT_IW'(i)))   r_st[i] <= ST_FREE;
        r_q[i] <= w_q_nxt[i];
      end
      r_qcnt      <= w_qcnt_nxt;
      r_cpu_valid <= (w_qcnt_nxt != '0);

      r_alloc_gnt <= w_alloc_fire;
      if (w_alloc_fire) begin
        r_alloc_slot <= w_free_idx;
        r_alloc_base <= slot_base(w_free_idx);
      end

      if (w_accept) begin
        r_out_valid <= 1'b0;
        r_rr_ptr    <= r_out_slot;
      end else if (w_offer) begin
        r_out_valid <= 1'b1;
        r_out_slot  <= w_arb_idx;
        r_out_base  <= slot_base(w_arb_idx);
      end

      r_cnt_in   <= r_cnt_in + {31'd0, w_fill_ok};
      r_cnt_out  <= r_cnt_out + {31'd0, w_rel_ok};
      r_cnt_drop <= r_cnt_drop + {31'd0, w_pop & i_cpu_drop} + {31'd0, w_wdt_fire};
      r_err      <= r_err | w_fill_err | w_pop_err | w_rel_err | w_wdt_fire;
    end
  end

  assign o_alloc_gnt     = r_alloc_gnt;
  assign o_alloc_slot    = r_alloc_slot;
  assign o_alloc_base    = r_alloc_base;
  assign o_cpu_pkt_valid = r_cpu_valid;
  assign o_cpu_pkt_slot  = r_q[0];
  assign o_out_valid     = r_out_valid;
  assign o_out_slot      = r_out_slot;
  assign o_out_base      = r_out_base;
  assign o_cnt_in        = r_cnt_in;
  assign o_cnt_out       = r_cnt_out;
  assign o_cnt_drop      = r_cnt_drop;
  assign o_err_sticky    = r_err;

endmodule

// File: tb/tb_pkt_slot_sched.sv
// Directed bench for pkt_slot_sched: allocation spacing, CPU queue order, drop, RR egress, errors, reset.
// Latency: inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: egress ready driven by the scenarios; every wait is cycle-bounded.
module tb_pkt_slot_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [1:0]  alloc_slot;
  logic [8:0]  alloc_base;
  logic        fill_done;
  logic [1:0]  fill_slot;
  logic        cpu_pkt_valid;
  logic [1:0]  cpu_pkt_slot;
  logic        cpu_done;
  logic        cpu_drop;
  logic        out_valid;
  logic [1:0]  out_slot;
  logic [8:0]  out_base;
  logic        out_ready;
  logic        rel;
  logic [1:0]  rel_slot;
  logic [31:0] cnt_in;
  logic [31:0] cnt_out;
  logic [31:0] cnt_drop;
  logic        err_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pkt_slot_sched #(.WDT_CYCLES(16'd20)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_alloc_req     (alloc_req),
    .o_alloc_gnt     (alloc_gnt),
    .o_alloc_slot    (alloc_slot),
    .o_alloc_base    (alloc_base),
    .i_fill_done     (fill_done),
    .i_fill_slot     (fill_slot),
    .o_cpu_pkt_valid (cpu_pkt_valid),
    .o_cpu_pkt_slot  (cpu_pkt_slot),
    .i_cpu_done      (cpu_done),
    .i_cpu_drop      (cpu_drop),
    .o_out_valid     (out_valid),
    .o_out_slot      (out_slot),
    .o_out_base      (out_base),
    .i_out_ready     (out_ready),
    .i_release       (rel),
    .i_release_slot  (rel_slot),
    .o_cnt_in        (cnt_in),
    .o_cnt_out       (cnt_out),
    .o_cnt_drop      (cnt_drop),
    .o_err_sticky    (err_sticky)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req = 1'b0; fill_done = 1'b0; fill_slot = 2'd0;
    cpu_done  = 1'b0; cpu_drop  = 1'b0; out_ready = 1'b0;
    rel       = 1'b0; rel_slot  = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic grab(output logic [1:0] s, output bit ok);
    s = 2'd0;
    ok = 1'b0;
    alloc_req = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      step();
      if (alloc_gnt === 1'b1) begin
        ok = 1'b1;
        s  = alloc_slot;
      end
    end
    alloc_req = 1'b0;
  endtask

  task automatic fill(input logic [1:0] s);
    fill_done = 1'b1; fill_slot = s;
    step();
    fill_done = 1'b0;
  endtask

  task automatic cpu(input logic drop);
    cpu_done = 1'b1; cpu_drop = drop;
    step();
    cpu_done = 1'b0; cpu_drop = 1'b0;
  endtask

  task automatic release_slot(input logic [1:0] s);
    rel = 1'b1; rel_slot = s;
    step();
    rel = 1'b0;
  endtask

  task automatic setup_four();
    logic [1:0] s;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      grab(s, ok);
      total++;
      if (!ok || s !== 2'(i)) begin
        bad++;
        $display("FAIL setup_grant%0d: got ok=%0d slot=%0d, want slot=%0d", i, ok, s, i);
      end
    end
  endtask

  // Accept three egress offers in sequence, releasing each after acceptance
  task automatic egress_seq(input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2, input string tag);
    logic [1:0] exp_s [3];
    logic [1:0] s;
    bit got;
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        if (out_valid === 1'b1) got = 1'b1;
        else step();
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL %s_timeout%0d: out_valid never rose, want slot %0d", tag, n, exp_s[n]);
      end else begin
        s = out_slot;
        if (s !== exp_s[n]) begin
          bad++;
          $display("FAIL %s_order%0d: got slot %0d, want %0d", tag, n, s, exp_s[n]);
        end
        total++;
        if (out_base !== {exp_s[n], 7'd0}) begin
          bad++;
          $display("FAIL %s_base%0d: got %0d, want %0d", tag, n, out_base, {exp_s[n], 7'd0});
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s_drop%0d: out_valid got %0b after accept, want 0", tag, n, out_valid);
        end
        release_slot(s);
      end
    end
    out_ready = 1'b0;
    total++;
    if (cnt_out !== 32'd3) begin
      bad++;
      $display("FAIL %s_cnt_out: got %0d, want 3", tag, cnt_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({alloc_gnt, out_valid, cpu_pkt_valid, err_sticky} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got gnt/oval/cval/err=%b, want 0000", {alloc_gnt, out_valid, cpu_pkt_valid, err_sticky});
    end
    total++;
    if ({alloc_slot, alloc_base, out_slot, out_base, cpu_pkt_slot} !== 24'd0) begin
      bad++;
      $display("FAIL reset_slots: got %h, want 0", {alloc_slot, alloc_base, out_slot, out_base, cpu_pkt_slot});
    end
    total++;
    if ({cnt_in, cnt_out, cnt_drop} !== 96'd0) begin
      bad++;
      $display("FAIL reset_counts: got in=%0d out=%0d drop=%0d, want 0", cnt_in, cnt_out, cnt_drop);
    end
  endtask

  task automatic test_alloc();
    logic [1:0] es;
    bit eg;
    alloc_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      eg = (c % 2 == 1) && (c <= 7);
      es = 2'((c - 1) / 2);
      total++;
      if (alloc_gnt !== eg) begin
        bad++;
        $display("FAIL alloc_gnt_c%0d: got %0b, want %0b", c, alloc_gnt, eg);
      end
      if (eg) begin
        total++;
        if (alloc_slot !== es || alloc_base !== {es, 7'd0}) begin
          bad++;
          $display("FAIL alloc_slot_c%0d: got slot=%0d base=%0d, want slot=%0d base=%0d", c, alloc_slot, alloc_base, es, {es, 7'd0});
        end
      end
    end
    alloc_req = 1'b0;
  endtask

  task automatic test_fill_cpu();
    fill(2'd2);
    total++;
    if (cpu_pkt_valid !== 1'b1 || cpu_pkt_slot !== 2'd2) begin
      bad++;
      $display("FAIL cpu_head_first: got valid=%0b slot=%0d, want 1/2", cpu_pkt_valid, cpu_pkt_slot);
    end
    fill(2'd0);
    total++;
    if (cpu_pkt_slot !== 2'd2 || cnt_in !== 32'd2) begin
      bad++;
      $display("FAIL cpu_head_hold: got slot=%0d cnt_in=%0d, want 2/2", cpu_pkt_slot, cnt_in);
    end
    cpu(1'b0);
    total++;
    if (cpu_pkt_valid !== 1'b1 || cpu_pkt_slot !== 2'd0) begin
      bad++;
      $display("FAIL cpu_head_next: got valid=%0b slot=%0d, want 1/0", cpu_pkt_valid, cpu_pkt_slot);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_slot !== 2'd2 || out_base !== 9'd256) begin
      bad++;
      $display("FAIL fwd_offer: got valid=%0b slot=%0d base=%0d, want 1/2/256", out_valid, out_slot, out_base);
    end
    step();
    step();
    total++;
    if (out_valid !== 1'b1 || out_slot !== 2'd2) begin
      bad++;
      $display("FAIL offer_stable: got valid=%0b slot=%0d, want 1/2", out_valid, out_slot);
    end
  endtask

  task automatic test_drop();
    bit seen_out;
    do_reset();
    setup_four();
    fill(2'd1);
    total++;
    if (cpu_pkt_slot !== 2'd1 || cpu_pkt_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_head: got valid=%0b slot=%0d, want 1/1", cpu_pkt_valid, cpu_pkt_slot);
    end
    cpu_done = 1'b1; cpu_drop = 1'b1; alloc_req = 1'b1;
    step();
    cpu_done = 1'b0; cpu_drop = 1'b0;
    total++;
    if (alloc_gnt !== 1'b0 || cnt_drop !== 32'd1 || cpu_pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL drop_same_cycle: got gnt=%0b cnt_drop=%0d cval=%0b, want 0/1/0", alloc_gnt, cnt_drop, cpu_pkt_valid);
    end
    step();
    alloc_req = 1'b0;
    total++;
    if (alloc_gnt !== 1'b1 || alloc_slot !== 2'd1 || alloc_base !== 9'd128) begin
      bad++;
      $display("FAIL drop_realloc: got gnt=%0b slot=%0d base=%0d, want 1/1/128", alloc_gnt, alloc_slot, alloc_base);
    end
    seen_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid !== 1'b0) seen_out = 1'b1;
    end
    total++;
    if (seen_out) begin
      bad++;
      $display("FAIL drop_no_egress: got out_valid=1 after drop, want 0");
    end
  endtask

  task automatic test_egress_order();
    do_reset();
    setup_four();
    fill(2'd0); fill(2'd1); fill(2'd3);
    cpu(1'b0); cpu(1'b0); cpu(1'b0);
    egress_seq(2'd0, 2'd1, 2'd3, "eg013");
  endtask

  task automatic test_rr_pointer();
    do_reset();
    setup_four();
    fill(2'd1); fill(2'd0); fill(2'd3);
    cpu(1'b0); cpu(1'b0); cpu(1'b0);
    egress_seq(2'd1, 2'd3, 2'd0, "rr130");
  endtask

  task automatic test_errors();
    logic [1:0] s;
    bit ok;
    do_reset();
    release_slot(2'd0);
    total++;
    if (err_sticky !== 1'b1 || cnt_out !== 32'd0) begin
      bad++;
      $display("FAIL err_release_free: got err=%0b cnt_out=%0d, want 1/0", err_sticky, cnt_out);
    end
    grab(s, ok);
    total++;
    if (!ok || s !== 2'd0) begin
      bad++;
      $display("FAIL err_free_kept: got ok=%0d slot=%0d, want slot 0", ok, s);
    end

    do_reset();
    total++;
    if (err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared: got %0b, want 0", err_sticky);
    end
    grab(s, ok);
    fill(2'd0);
    fill(2'd0);
    total++;
    if (err_sticky !== 1'b1 || cnt_in !== 32'd1) begin
      bad++;
      $display("FAIL err_fill_cpu: got err=%0b cnt_in=%0d, want 1/1", err_sticky, cnt_in);
    end
    cpu(1'b0);
    total++;
    if (cpu_pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_no_dup_push: got cpu_pkt_valid=%0b, want 0", cpu_pkt_valid);
    end
    for (int i = 0; i < 5; i++) step();
    total++;
    if (err_sticky !== 1'b1 || out_valid !== 1'b1 || out_slot !== 2'd0) begin
      bad++;
      $display("FAIL err_hold: got err=%0b oval=%0b oslot=%0d, want 1/1/0", err_sticky, out_valid, out_slot);
    end

    do_reset();
    total++;
    if (out_valid !== 1'b0 || err_sticky !== 1'b0 || cnt_in !== 32'd0) begin
      bad++;
      $display("FAIL midop_reset: got oval=%0b err=%0b cnt_in=%0d, want 0/0/0", out_valid, err_sticky, cnt_in);
    end
    grab(s, ok);
    total++;
    if (!ok || s !== 2'd0) begin
      bad++;
      $display("FAIL midop_realloc: got ok=%0d slot=%0d, want slot 0", ok, s);
    end
    cpu(1'b0);
    total++;
    if (err_sticky !== 1'b1 || cpu_pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_cpu_empty: got err=%0b cval=%0b, want 1/0", err_sticky, cpu_pkt_valid);
    end
  endtask

`ifdef PKT_SCHED_WDT_EN
  task automatic test_watchdog();
    logic [1:0] s;
    bit ok;
    bit early;
    do_reset();
    grab(s, ok);
    fill(2'd0);
    early = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (cpu_pkt_valid !== 1'b1) early = 1'b1;
      step();
    end
    total++;
    if (early || cpu_pkt_valid !== 1'b1) begin
      bad++;
      $display("FAIL wdt_early: slot left CPU before 20 cycles, want it held");
    end
    step();
    total++;
    if (cpu_pkt_valid !== 1'b0 || cnt_drop !== 32'd1 || err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL wdt_fire: got cval=%0b cnt_drop=%0d err=%0b, want 0/1/1", cpu_pkt_valid, cnt_drop, err_sticky);
    end
    grab(s, ok);
    total++;
    if (!ok || s !== 2'd0) begin
      bad++;
      $display("FAIL wdt_freed: got ok=%0d slot=%0d, want slot 0", ok, s);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc();
    test_fill_cpu();
    test_drop();
    test_egress_order();
    test_rr_pointer();
    test_errors();
`ifdef PKT_SCHED_WDT_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
